// File: rtl/arith_serdes_pkg.sv
// Shared types and legality bounds for the byte-serial adder front end.
package arith_serdes_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN   = 8;
  localparam int WIDTH_MAX   = 64;
  localparam int LATENCY_MAX = 7;

  function automatic int nbytes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/arith_serdes_byte_deser.sv
// Byte-indexed operand register file: bytes 0..NB-1 form A, NB..2NB-1 form B.
module byte_deser #(
  parameter int NB = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_restart,
  input  logic [7:0]      data_in,
  output logic [8*NB-1:0] op_a,
  output logic [8*NB-1:0] op_b,
  output logic            full
);

  localparam int CW = $clog2(2*NB+1);

  logic [16*NB-1:0] regs_q, regs_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign full = (cnt_q == CW'(2*NB));
  assign op_a = regs_q[8*NB-1:0];
  assign op_b = regs_q[16*NB-1:8*NB];

  // A restart overwrites A byte 0 and leaves the remaining bytes as they were.
  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (wr_restart) begin
      regs_d[7:0] = data_in;
      cnt_d       = CW'(1);
    end else if (wr_en && !full) begin
      regs_d[int'(cnt_q)*8 +: 8] = data_in;
      cnt_d                      = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/arith_serdes.sv
// Deserialises two operands, drives an external adder, captures {carry,sum}
// after LATENCY+1 cycles and serves the result back one byte at a time.
module arith_serdes
  import arith_serdes_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             load,
  input  logic             start_calc,
  input  logic             output_result,
  input  logic             sub,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             cin,
  input  logic [WIDTH:0]   z,
  output logic [7:0]       data_out,
  output logic             busy,
  output logic             done,
  output logic             carry
);

  localparam int NB = nbytes(WIDTH);
  localparam int RW = (NB > 1) ? $clog2(NB) : 1;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || (WIDTH % 8) != 0 ||
      LATENCY < 0 || LATENCY > LATENCY_MAX) begin : g_bad_params
    $error("arith_serdes: illegal WIDTH=%0d / LATENCY=%0d", WIDTH, LATENCY);
  end

  state_e           state_q, state_d;
  logic [2:0]       lat_q, lat_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [RW-1:0]    rd_idx_q, rd_idx_d;

  logic             full;
  logic             wr_en;
  logic             wr_restart;
  logic [WIDTH-1:0] op_a, op_b;

  // A full set with a start pending turns the same-cycle load into a no-op.
  assign wr_en      = load && (state_q == LOAD) && !(start_calc && full);
  assign wr_restart = load && (state_q == DONE);

  byte_deser #(.NB(NB)) u_deser (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_restart (wr_restart),
    .data_in    (data_in),
    .op_a       (op_a),
    .op_b       (op_b),
    .full       (full)
  );

  assign a        = op_a;
  assign b        = sub_q ? ~op_b : op_b;
  assign cin      = sub_q;
  assign busy     = (state_q == CALC);
  assign done     = (state_q == DONE);
  assign carry    = carry_q;
  assign data_out = done ? result_q[int'(rd_idx_q)*8 +: 8] : 8'h00;

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    sub_d    = sub_q;
    result_d = result_q;
    carry_d  = carry_q;
    rd_idx_d = rd_idx_q;
    unique case (state_q)
      LOAD: begin
        if (start_calc && full) begin
          state_d = CALC;
          sub_d   = sub;
          lat_d   = '0;
        end
      end
      CALC: begin
        if (lat_q == 3'(LATENCY)) begin
          result_d = z[WIDTH-1:0];
          carry_d  = z[WIDTH];
          rd_idx_d = '0;
          state_d  = DONE;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      DONE: begin
        if (load) begin
          state_d = LOAD;
        end else if (output_result) begin
          rd_idx_d = (rd_idx_q == RW'(NB-1)) ? '0 : rd_idx_q + RW'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      lat_q    <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      rd_idx_q <= rd_idx_d;
    end
  end

endmodule

// File: tb/tb_arith_serdes.sv
// Directed bench: one instance with LATENCY=0, one with LATENCY=3, each with its own adder model.
module tb_arith_serdes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic        rst0 = 1'b1, load0 = 1'b0, start0 = 1'b0, or0 = 1'b0, sub0 = 1'b0;
  logic [7:0]  din0 = 8'h00, dout0;
  logic [31:0] a0, b0;
  logic        cin0, busy0, done0, carry0;
  logic [32:0] z0;

  logic        rst3 = 1'b1, load3 = 1'b0, start3 = 1'b0, or3 = 1'b0, sub3 = 1'b0;
  logic [7:0]  din3 = 8'h00, dout3;
  logic [31:0] a3, b3;
  logic        cin3, busy3, done3, carry3;
  logic [32:0] z3;

  assign z0 = {1'b0, a0} + {1'b0, b0} + {32'd0, cin0};
  assign z3 = {1'b0, a3} + {1'b0, b3} + {32'd0, cin3};

  arith_serdes #(.WIDTH(32), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst0), .data_in(din0), .load(load0), .start_calc(start0),
    .output_result(or0), .sub(sub0), .a(a0), .b(b0), .cin(cin0), .z(z0),
    .data_out(dout0), .busy(busy0), .done(done0), .carry(carry0)
  );

  arith_serdes #(.WIDTH(32), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst3), .data_in(din3), .load(load3), .start_calc(start3),
    .output_result(or3), .sub(sub3), .a(a3), .b(b3), .cin(cin3), .z(z3),
    .data_out(dout3), .busy(busy3), .done(done3), .carry(carry3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ld0(input logic [7:0] v);
    load0 = 1'b1; din0 = v; tick(); load0 = 1'b0;
  endtask

  task automatic ld0_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) ld0(w[i*8 +: 8]);
  endtask

  task automatic start0_op(input logic s);
    start0 = 1'b1; sub0 = s; tick(); start0 = 1'b0; sub0 = 1'b0;
  endtask

  task automatic rd0();
    or0 = 1'b1; tick(); or0 = 1'b0;
  endtask

  task automatic ld3(input logic [7:0] v);
    load3 = 1'b1; din3 = v; tick(); load3 = 1'b0;
  endtask

  task automatic read_word0(input string tag, input logic [31:0] exp);
    for (int i = 0; i < 4; i++) begin
      chk(tag, {56'd0, dout0}, {56'd0, exp[i*8 +: 8]});
      rd0();
    end
  endtask

  initial begin
    tick(); tick();
    rst0 = 1'b0; rst3 = 1'b0;

    chk("rst_busy",  {63'd0, busy0},  64'd0);
    chk("rst_done",  {63'd0, done0},  64'd0);
    chk("rst_dout",  {56'd0, dout0},  64'd0);
    chk("rst_a",     {32'd0, a0},     64'd0);
    chk("rst_b",     {32'd0, b0},     64'd0);
    chk("rst_cin",   {63'd0, cin0},   64'd0);
    chk("rst_carry", {63'd0, carry0}, 64'd0);

    // basic add, LATENCY=0
    ld0_word(32'h12345678);
    ld0_word(32'h00000001);
    chk("load_a", {32'd0, a0}, 64'h12345678);
    chk("load_b", {32'd0, b0}, 64'h00000001);
    start0_op(1'b0);
    chk("add_busy1", {63'd0, busy0}, 64'd1);
    chk("add_done1", {63'd0, done0}, 64'd0);
    tick();
    chk("add_busy2", {63'd0, busy0}, 64'd0);
    chk("add_done2", {63'd0, done0}, 64'd1);
    chk("add_carry", {63'd0, carry0}, 64'd0);
    read_word0("add_byte", 32'h12345679);
    chk("add_wrap", {56'd0, dout0}, 64'h79);

    // overflow add; first load from DONE restarts the set
    ld0(8'hFF);
    chk("restart_done", {63'd0, done0}, 64'd0);
    chk("restart_a0",   {56'd0, a0[7:0]}, 64'hFF);
    ld0(8'hFF); ld0(8'hFF); ld0(8'hFF);
    ld0_word(32'h00000001);
    start0_op(1'b0);
    tick();
    chk("ovf_carry", {63'd0, carry0}, 64'd1);
    read_word0("ovf_byte", 32'h00000000);

    // gating: 7 bytes then start is ignored
    ld0(8'h11); ld0(8'h22); ld0(8'h33); ld0(8'h44);
    ld0(8'h55); ld0(8'h66); ld0(8'h77);
    start0_op(1'b0);
    chk("gate_busy", {63'd0, busy0}, 64'd0);
    chk("gate_done", {63'd0, done0}, 64'd0);
    ld0(8'h88);
    ld0(8'h99);
    chk("ninth_a", {32'd0, a0}, 64'h44332211);
    chk("ninth_b", {32'd0, b0}, 64'h88776655);
    load0 = 1'b1; din0 = 8'hAA; start0 = 1'b1;
    tick();
    load0 = 1'b0; start0 = 1'b0;
    chk("ldst_busy", {63'd0, busy0}, 64'd1);
    chk("ldst_b",    {32'd0, b0},    64'h88776655);
    tick();
    chk("gate_carry", {63'd0, carry0}, 64'd0);
    read_word0("gate_byte", 32'hCCAA8866);

    // subtract 5 - 7
    ld0_word(32'h00000005);
    ld0_word(32'h00000007);
    start0_op(1'b1);
    chk("sub_b",   {32'd0, b0},    64'hFFFFFFF8);
    chk("sub_cin", {63'd0, cin0},  64'd1);
    tick();
    chk("sub_carry", {63'd0, carry0}, 64'd0);
    read_word0("sub_byte", 32'hFFFFFFFE);

    // subtract 7 - 5
    ld0_word(32'h00000007);
    ld0_word(32'h00000005);
    start0_op(1'b1);
    tick();
    chk("sub2_carry", {63'd0, carry0}, 64'd1);
    read_word0("sub2_byte", 32'h00000002);

    // load + output_result in DONE: load wins
    load0 = 1'b1; or0 = 1'b1; din0 = 8'hAB;
    tick();
    load0 = 1'b0; or0 = 1'b0;
    chk("ldrd_done", {63'd0, done0}, 64'd0);
    chk("ldrd_a0",   {56'd0, a0[7:0]}, 64'hAB);

    // reset mid-CALC
    ld0(8'h00); ld0(8'h00); ld0(8'h00);
    ld0_word(32'h00000001);
    start0_op(1'b0);
    chk("mid_busy", {63'd0, busy0}, 64'd1);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    chk("mid_rst_busy",  {63'd0, busy0},  64'd0);
    chk("mid_rst_done",  {63'd0, done0},  64'd0);
    chk("mid_rst_dout",  {56'd0, dout0},  64'd0);
    chk("mid_rst_carry", {63'd0, carry0}, 64'd0);

    // LATENCY=3 timing with strobes held during CALC
    ld3(8'h10); ld3(8'h00); ld3(8'h00); ld3(8'h00);
    ld3(8'h20); ld3(8'h00); ld3(8'h00); ld3(8'h00);
    start3 = 1'b1; sub3 = 1'b0;
    tick();
    load3 = 1'b1; din3 = 8'hEE; or3 = 1'b1; sub3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("lat3_busy", {63'd0, busy3}, 64'd1);
      chk("lat3_done", {63'd0, done3}, 64'd0);
      tick();
    end
    load3 = 1'b0; or3 = 1'b0; start3 = 1'b0; sub3 = 1'b0;
    chk("lat3_busy_end", {63'd0, busy3}, 64'd0);
    chk("lat3_done_end", {63'd0, done3}, 64'd1);
    chk("lat3_dout",     {56'd0, dout3}, 64'h30);
    chk("lat3_a",        {32'd0, a3},    64'h10);
    chk("lat3_b",        {32'd0, b3},    64'h20);
    chk("lat3_carry",    {63'd0, carry3}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arith_serdes.md
# arith_serdes

Byte-serial operand/result front end for the wide adders. It sits between the 8-bit pin interface and a combinational or pipelined adder (CLA or RCA). It deserialises two WIDTH-bit operands from an 8-bit stream and drives them, with carry-in, to the external adder. It waits a parametrised latency, captures sum plus carry, then serialises the result back out byte by byte. It adds a subtract mode, a busy/done handshake and load/start gating for partially loaded operands.

## Interface
- WIDTH, 32, operand width; multiple of 8, 8..64; NB = WIDTH/8 bytes per operand
- LATENCY, 0, extra adder pipeline cycles before capture; 0..7
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- data_in  in  8  operand byte stream
- load  in  1  strobe: capture data_in as next operand byte
- start_calc  in  1  strobe: begin calculation
- output_result  in  1  strobe: advance data_out to next result byte
- sub  in  1  mode, sampled at accepted start: 0 add, 1 subtract
- a  out  WIDTH  operand A to adder
- b  out  WIDTH  operand B to adder (inverted in subtract mode)
- cin  out  1  adder carry-in
- z  in  WIDTH+1  adder result {carry, sum}
- data_out  out  8  current result byte
- busy  out  1  calculation in flight
- done  out  1  result valid
- carry  out  1  captured z[WIDTH]

## Operation
- States: LOAD, CALC, DONE.
- LOAD: each load writes data_in into byte idx of A for idx 0..NB-1, then into B for idx NB..2NB-1, LSB byte first. Loads beyond 2NB bytes are ignored. start_calc is accepted only when all 2NB bytes are loaded; otherwise it is ignored.
- Accepted start: latch sub, go to CALC, busy=1, clear the latency counter.
- a = A register; b = sub ? ~B : B; cin = sub. These outputs are held stable through CALC and DONE.
- CALC: stay LATENCY+1 cycles. On the last cycle, register z into the result (WIDTH bits) and carry, then go to DONE.
- Subtract: the sum is A−B mod 2^WIDTH; carry=1 means no borrow (A≥B).
- DONE: done=1, data_out = result byte rd_idx, with rd_idx=0 on entry. Each output_result increments rd_idx; after NB−1 it wraps to 0. The result is readable any number of times.
- A load in DONE starts a new operand set: the load byte is written to A byte 0, done clears, the byte counter becomes 1, and the state goes to LOAD.
- A load in LOAD state clears nothing else. Operands persist, so a re-start after a complete load reuses the registers.
- Simultaneous events:
  - load+start_calc in LOAD with the set full: start wins, load ignored.
  - load+output_result in DONE: load wins.
  - All strobes are ignored in CALC.

## Timing
- Reset (rst high at a clk edge) clears everything: all registers 0, state LOAD, byte counter 0, a=b=0, cin=0, data_out=0, busy=0, done=0, carry=0. Reset mid-CALC or mid-read aborts with no partial output.
- start accepted at edge t: busy=1 from t+1 through t+1+LATENCY. At t+2+LATENCY, busy=0, done=1 and data_out = result byte 0.
- Handshake latency: start to done is LATENCY+2 edges.
- output_result at edge u: the new byte appears after edge u (registered read index; data_out is combinational from the result register and index).
- Byte counter and rd_idx are sized $clog2(2NB+1) and $clog2(NB) (minimum 1 bit).

## Structure
- Package arith_serdes_pkg:
  - state enum (LOAD, CALC, DONE)
  - function nbytes(width)
  - localparam bounds for the WIDTH/LATENCY legality check; elaboration $error when violated
- Sub-module byte_deser #(NB): byte-indexed write into a 2·NB-byte register file, with the full flag. arith_serdes holds the FSM, latency counter, result register and output mux.
- Adders stay external; top level wires a/b/cin/z to the cla or rca instance.

## Test plan
- WIDTH=32, LATENCY=0: load 78 56 34 12 then 01 00 00 00, start, sub=0 → busy exactly one cycle. Then done; read bytes 79 56 34 12, carry=0; fifth output_result wraps to 79.
- Add overflow: A=FFFFFFFF, B=00000001 → result 00000000, carry=1.
- Subtract: A=5, B=7, sub=1 → b=FFFFFFF8, cin=1, result FFFFFFFE, carry=0. Also A=7, B=5 → 00000002, carry=1.
- Gating: 7 loads then start_calc → ignored, busy stays 0. The 8th load then start → accepted. A 9th load before start → ignored, operands unchanged.
- LATENCY=3: start at edge t → busy high t+1..t+4, done at t+5. Strobes during CALC have no effect.
- Reset mid-CALC → next cycle busy=0, done=0, data_out=0, carry=0. Load in DONE → done drops, first byte lands in A[7:0].
